// File: rtl/adder_pkg.sv
// Shared arithmetic-pipeline definitions: stage-count helper and the control
// part of a pipeline stage record.
package adder_pkg;

    // Guarded against CHUNK < 1 so the caller's parameter check can report it.
    function automatic int stages(input int width, input int chunk);
        return (chunk < 1) ? 1 : width / chunk;
    endfunction

    typedef struct packed {
        logic valid;
        logic carry;
        logic sub;
    } stage_ctrl_t;

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple adder; c_msb is the carry into the top bit,
// used for signed overflow when this is the most significant chunk.
module adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    always_comb begin
        logic c;
        // NOTE: blocking assignments here build a combinational ripple chain;
        // every output gets a default first so no latch is inferred.
        c     = ci;
        c_msb = ci;
        s     = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) c_msb = c;
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        co = c;
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined two's-complement adder/subtractor: one CHUNK-bit slice of the
// carry chain per registered stage, with a global valid/ready stall.
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = stages(WIDTH, CHUNK);
    localparam int LAST   = STAGES - 1;

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("pipe_adder: WIDTH must be a positive multiple of CHUNK");
    end

    // Operands are kept shifted down so each stage always consumes bits [CHUNK-1:0].
    typedef struct packed {
        stage_ctrl_t      ctrl;
        logic             ovf;
        logic [WIDTH-1:0] psum;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
    } stage_t;

    logic             advance;
    stage_t           src_w   [STAGES];
    stage_t           stage_d [STAGES];
    stage_t           stage_q [STAGES];
    logic [CHUNK-1:0] x_w     [STAGES];
    logic [CHUNK-1:0] y_w     [STAGES];
    logic [CHUNK-1:0] s_w     [STAGES];
    logic             co_w    [STAGES];
    logic             cmsb_w  [STAGES];

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign src_w[k] = '{
                ctrl:  '{valid: in_valid, carry: cin, sub: sub},
                ovf:   1'b0,
                psum:  '0,
                a_rem: a,
                b_rem: b
            };
        end else begin : g_body
            assign src_w[k] = stage_q[k-1];
        end

        assign x_w[k] = src_w[k].a_rem[CHUNK-1:0];
        assign y_w[k] = src_w[k].b_rem[CHUNK-1:0] ^ {CHUNK{src_w[k].ctrl.sub}};

        adder_chunk #(.CHUNK(CHUNK)) u_chunk (
            .x     (x_w[k]),
            .y     (y_w[k]),
            .ci    (src_w[k].ctrl.carry),
            .s     (s_w[k]),
            .co    (co_w[k]),
            .c_msb (cmsb_w[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            stage_d[k]                      = src_w[k];
            stage_d[k].ctrl.carry           = co_w[k];
            stage_d[k].ovf                  = cmsb_w[k] ^ co_w[k];
            stage_d[k].psum[k*CHUNK +: CHUNK] = s_w[k];
            stage_d[k].a_rem                = src_w[k].a_rem >> CHUNK;
            stage_d[k].b_rem                = src_w[k].b_rem >> CHUNK;
        end
    end

    // NOTE: sequential state uses non-blocking assignments, and every stage
    // register (data included) is reset so no stale bundle survives reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) stage_q[k] <= stage_d[k];
        end
    end

    assign out_valid = stage_q[LAST].ctrl.valid;
    assign sum       = stage_q[LAST].psum;
    assign cout      = stage_q[LAST].ctrl.carry;
    assign ovf       = stage_q[LAST].ovf;

    // Operand remainders and mode bit are fully consumed by the last stage.
    logic unused_last;
    assign unused_last = ^{stage_q[LAST].ctrl.sub, stage_q[LAST].a_rem, stage_q[LAST].b_rem};

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: a 16/4 instance and an 8/8 instance,
// checked against an arithmetic reference model with in-order result queues.
module tb_pipe_adder;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          t;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        v16, r16, cin16, sub16, ov16, or16, co16, of16;
    logic [15:0] a16, b16, s16;
    logic        v8, r8, cin8, sub8, ov8, or8, co8, of8;
    logic [7:0]  a8, b8, s8;

    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    bit   lat_mode = 0;
    bit   acc16, acc8;
    exp_t q16[$];
    exp_t q8[$];
    exp_t nxt16, nxt8;

    pipe_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(r16),
        .a(a16), .b(b16), .cin(cin16), .sub(sub16),
        .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .ovf(of16)
    );

    pipe_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: unsigned modular sum for sum/cout, true signed sum for ovf.
    function automatic exp_t model(input int w, input logic [15:0] x, input logic [15:0] y,
                                   input logic ci, input logic sb);
        exp_t   e;
        longint m    = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint ux   = longint'(x) & m;
        longint uy   = longint'(sb ? ~y : y) & m;
        longint tot  = ux + uy + longint'(ci);
        longint sx   = (ux >= half) ? ux - 2 * half : ux;
        longint sy   = (uy >= half) ? uy - 2 * half : uy;
        longint st   = sx + sy + longint'(ci);
        e.sum  = 16'(tot & m);
        e.cout = ((tot >> w) & 1) != 0;
        e.ovf  = (st >= half) || (st < -half);
        e.t    = 0;
        return e;
    endfunction

    // One clock: sample at the falling edge, score both channels, then step.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        check("in_ready16", r16, !(ov16 && !or16));
        if (ov16) begin
            if (q16.size() == 0) check("spurious16", ov16, 1'b0);
            else begin
                check("sum16", s16, q16[0].sum);
                check("cout16", co16, q16[0].cout);
                check("ovf16", of16, q16[0].ovf);
                if (or16) begin
                    if (lat_mode) check("latency16", cyc - q16[0].t, 4);
                    void'(q16.pop_front());
                end
            end
        end
        acc16 = v16 && r16;
        if (acc16) begin e = nxt16; e.t = cyc; q16.push_back(e); end

        check("in_ready8", r8, !(ov8 && !or8));
        if (ov8) begin
            if (q8.size() == 0) check("spurious8", ov8, 1'b0);
            else begin
                check("sum8", {8'h00, s8}, q8[0].sum);
                check("cout8", co8, q8[0].cout);
                check("ovf8", of8, q8[0].ovf);
                if (or8) begin
                    if (lat_mode) check("latency8", cyc - q8[0].t, 1);
                    void'(q8.pop_front());
                end
            end
        end
        acc8 = v8 && r8;
        if (acc8) begin e = nxt8; e.t = cyc; q8.push_back(e); end

        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic new16();
        a16 = 16'($urandom); b16 = 16'($urandom);
        cin16 = 1'($urandom); sub16 = 1'($urandom);
        nxt16 = model(16, a16, b16, cin16, sub16);
    endtask

    task automatic new8();
        a8 = 8'($urandom); b8 = 8'($urandom);
        cin8 = 1'($urandom); sub8 = 1'($urandom);
        nxt8 = model(8, {8'h00, a8}, {8'h00, b8}, cin8, sub8);
    endtask

    task automatic send16(input logic [15:0] x, input logic [15:0] y, input logic ci,
                          input logic sb, input logic [15:0] es, input logic ec, input logic eo);
        lat_mode = 1; or16 = 1'b1;
        a16 = x; b16 = y; cin16 = ci; sub16 = sb; v16 = 1'b1;
        nxt16 = '{sum: es, cout: ec, ovf: eo, t: 0};
        tick();
        v16 = 1'b0;
        repeat (6) tick();
        check("directed_done16", q16.size(), 0);
        lat_mode = 0;
    endtask

    task automatic send8(input logic [7:0] x, input logic [7:0] y, input logic ci,
                         input logic sb, input logic [7:0] es, input logic ec, input logic eo);
        lat_mode = 1; or8 = 1'b1;
        a8 = x; b8 = y; cin8 = ci; sub8 = sb; v8 = 1'b1;
        nxt8 = '{sum: {8'h00, es}, cout: ec, ovf: eo, t: 0};
        tick();
        v8 = 1'b0;
        repeat (3) tick();
        check("directed_done8", q8.size(), 0);
        lat_mode = 0;
    endtask

    // n random bundles, producer holds each until accepted, random back-pressure.
    task automatic random16(input int n, input bit gaps);
        int sent = 0;
        int guard = 0;
        new16();
        v16 = 1'b1;
        while (sent < n && guard < 20 * n) begin
            or16 = 1'($urandom);
            tick();
            if (acc16) begin
                sent++;
                new16();
            end
            v16 = (sent < n) && (!gaps || $urandom_range(0, 3) != 0);
            guard++;
        end
        v16 = 1'b0;
        check("sent16", sent, n);
        guard = 0;
        while (q16.size() > 0 && guard < 200) begin
            or16 = 1'($urandom);
            tick();
            guard++;
        end
        or16 = 1'b1;
        check("drain16", q16.size(), 0);
    endtask

    task automatic random8(input int n);
        int sent = 0;
        int guard = 0;
        new8();
        v8 = 1'b1;
        while (sent < n && guard < 20 * n) begin
            or8 = 1'($urandom);
            tick();
            if (acc8) begin
                sent++;
                new8();
            end
            v8 = (sent < n);
            guard++;
        end
        v8 = 1'b0;
        check("sent8", sent, n);
        guard = 0;
        while (q8.size() > 0 && guard < 100) begin
            or8 = 1'($urandom);
            tick();
            guard++;
        end
        or8 = 1'b1;
        check("drain8", q8.size(), 0);
    endtask

    initial begin
        // Reset held with random valid traffic on the inputs.
        rst_n = 1'b0;
        v16 = 1'b1; or16 = 1'b1; new16();
        v8  = 1'b1; or8  = 1'b1; new8();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid16", ov16, 1'b0);
        check("rst_sum16", s16, 16'h0000);
        check("rst_cout16", co16, 1'b0);
        check("rst_ovf16", of16, 1'b0);
        check("rst_out_valid8", ov8, 1'b0);
        check("rst_sum8", s8, 8'h00);
        v16 = 1'b0; v8 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready16", r16, 1'b1);
        check("post_rst_in_ready8", r8, 1'b1);

        // Directed corner cases, 4-cycle and 1-cycle latency.
        send16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        send16(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        send16(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        send8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        send8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        send8(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);

        // Back-pressure: 10 back-to-back bundles, then a longer run with gaps.
        random16(10, 1'b0);
        random16(150, 1'b1);
        random8(40);

        // Reset with bundles in flight (3 in the 16-bit pipe, 1 stalled in the 8-bit).
        or16 = 1'b1; or8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            new16(); v16 = 1'b1;
            new8();  v8  = 1'b1;
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid16", ov16, 1'b0);
        check("midrst_sum16", s16, 16'h0000);
        check("midrst_cout16", co16, 1'b0);
        check("midrst_ovf16", of16, 1'b0);
        check("midrst_in_ready16", r16, 1'b1);
        check("midrst_out_valid8", ov8, 1'b0);
        check("midrst_in_ready8", r8, 1'b1);
        q16.delete(); q8.delete();
        v16 = 1'b0; v8 = 1'b0; or8 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("post_midrst_ov16", ov16, 1'b0);
            check("post_midrst_ov8", ov8, 1'b0);
        end
        send16(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        send8(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
